serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. One subtraction takes WIDTH cycles in RUN,
// handling one bit per cycle LSB first, followed by a single DONE cycle that
// carries the done pulse. The result registers (diff, borrow and optionally
// ovf) change only on entry to DONE and otherwise hold the last result.
//
// Optional feature macro: SERSUB_OVF_EN
//   defined   -> an ovf output reports signed overflow of a - b
//   undefined -> no ovf port and no operand-MSB capture logic
//
// Ports
//   clk     in   1      single clock, rising edge
//   rst_n   in   1      synchronous active-low reset
//   start   in   1      begin a subtraction; honoured only in IDLE
//   a       in   WIDTH  minuend, captured on the accepted start edge
//   b       in   WIDTH  subtrahend, captured on the accepted start edge
//   busy    out  1      high in RUN and DONE
//   done    out  1      one-cycle pulse, new result valid
//   diff    out  WIDTH  (a - b) mod 2^WIDTH of the last completed operation
//   borrow  out  1      final borrow (unsigned a < b) of the last operation
//   ovf     out  1      signed overflow of the last operation (macro only)
//
// Handshake: start is a level request. An operation is accepted on a rising
// edge where rst_n=1, the FSM is in IDLE (busy=0) and start=1. start seen in
// RUN or DONE is dropped, not queued. Each accepted operation yields exactly
// one done pulse WIDTH edges after acceptance, unless reset aborts it.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             bw_q,     bw_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;

`ifdef SERSUB_OVF_EN
  // The shift registers lose the operand MSBs during the run, so the sign
  // bits are kept separately for the overflow decision.
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic             ovf_q,    ovf_d;
`endif

  // Per-bit subtract terms for the current LSB of the working operands.
  logic             a0;
  logic             b0;
  logic             bit_d;
  logic             bw_nxt;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    a0        = a_sh_q[0];
    b0        = b_sh_q[0];
    bit_d     = a0 ^ b0 ^ bw_q;
    bw_nxt    = (~a0 & b0) | (~(a0 ^ b0) & bw_q);
    // New bit enters at the MSB end; after WIDTH shifts the first bit
    // processed sits at bit 0.
    res_shift = (res_q >> 1) | {bit_d, {(WIDTH-1){1'b0}}};
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    bw_d     = bw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERSUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          bw_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERSUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        res_d  = res_shift;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        bw_d   = bw_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish on the same edge that enters DONE, using the final bit
          // and borrow produced this cycle.
          diff_d   = res_shift;
          borrow_d = bw_nxt;
`ifdef SERSUB_OVF_EN
          ovf_d    = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
`endif
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      bw_q     <= bw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERSUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERSUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule
